// File: rtl/ctrl_pkg.sv
// Shared definitions for the three-way access controller and its module-side requesters.
// Grant codes, request/done bit positions and the requester state encoding.
package ctrl_pkg;

    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_M1   = 2'd1,
        ACC_M2   = 2'd2,
        ACC_M3   = 2'd3
    } acc_code_e;

    localparam int M1_BIT = 0;
    localparam int M2_BIT = 1;
    localparam int M3_BIT = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_XFER   = 3'd2,
        ST_PAUSED = 3'd3,
        ST_DONE   = 3'd4
    } req_state_e;

endpackage

// File: rtl/module_requester_if.sv
// Job / grant / handshake bundle between a module datapath, the controller and one requester.
// The requester uses the master side; the environment driving jobs and grants uses slave.
interface module_requester_if #(
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
);
    logic             job_valid;
    logic [LEN_W-1:0] job_len;
    logic             job_ready;
    logic [1:0]       accmodule;
    logic             req;
    logic             done;
    logic             beat;
    logic [LEN_W-1:0] beat_idx;
    logic             busy;
    logic [CNT_W-1:0] nb_preempt;

    modport master (
        input  job_valid, job_len, accmodule,
        output job_ready, req, done, beat, beat_idx, busy, nb_preempt
    );

    modport slave (
        output job_valid, job_len, accmodule,
        input  job_ready, req, done, beat, beat_idx, busy, nb_preempt
    );
endinterface

// File: rtl/module_requester.sv
// Module-side requester: turns a local job into req/done, counts granted beats,
// and pauses/resumes across preemption without losing beats.
module module_requester
    import ctrl_pkg::*;
#(
    parameter int MODULE_ID = 1,
    parameter int LEN_W     = 8,
    parameter int CNT_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    module_requester_if.master bus
);

    localparam logic [1:0] MY_CODE = 2'(MODULE_ID);

    req_state_e       state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] nb_q, nb_d;
    logic             req_q, req_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             granted;
    logic             beat;

    assign granted = (bus.accmodule == MY_CODE);
    assign beat    = granted && (state_q == ST_REQ || state_q == ST_XFER || state_q == ST_PAUSED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= '0;
            nb_q    <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            nb_q    <= nb_d;
            req_q   <= req_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        nb_d    = nb_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.job_valid) begin
                    last_d  = bus.job_len;
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ, ST_PAUSED: begin
                if (beat) state_d = ST_XFER;
            end
            ST_XFER: begin
                if (!granted) begin
                    state_d = ST_PAUSED;
                    if (nb_q != '1) nb_d = nb_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // The last-beat compare also keeps the counter from ever passing last.
        if (beat) begin
            if (cnt_q == last_q) state_d = ST_DONE;
            else                 cnt_d   = cnt_q + 1'b1;
        end
    end

    always_comb begin
        req_d   = (state_d == ST_REQ) || (state_d == ST_XFER) || (state_d == ST_PAUSED);
        done_d  = (state_d == ST_DONE);
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    assign bus.job_ready  = ready_q;
    assign bus.req        = req_q;
    assign bus.done       = done_q;
    assign bus.beat       = beat;
    assign bus.beat_idx   = cnt_q;
    assign bus.busy       = busy_q;
    assign bus.nb_preempt = nb_q;

endmodule

// File: tb/tb_module_requester.sv
// Directed bench for module_requester: three instances (M1, M2, M3) share job_len/accmodule;
// only the selected instance sees job_valid, so grants to idle instances must be ignored.
module tb_module_requester;

    logic       clk;
    logic       reset;
    int         sel;
    logic       jv;
    logic [7:0] len;
    logic [1:0] acc;

    int n_chk;
    int n_err;

    module_requester_if #(.LEN_W(8), .CNT_W(8)) if1 ();
    module_requester_if #(.LEN_W(8), .CNT_W(8)) if2 ();
    module_requester_if #(.LEN_W(8), .CNT_W(2)) if3 ();

    module_requester #(.MODULE_ID(1), .LEN_W(8), .CNT_W(8)) u_m1 (.clk(clk), .reset(reset), .bus(if1));
    module_requester #(.MODULE_ID(2), .LEN_W(8), .CNT_W(8)) u_m2 (.clk(clk), .reset(reset), .bus(if2));
    module_requester #(.MODULE_ID(3), .LEN_W(8), .CNT_W(2)) u_m3 (.clk(clk), .reset(reset), .bus(if3));

    assign if1.job_valid = jv && (sel == 1);
    assign if2.job_valid = jv && (sel == 2);
    assign if3.job_valid = jv && (sel == 3);
    assign if1.job_len   = len;
    assign if2.job_len   = len;
    assign if3.job_len   = len;
    assign if1.accmodule = acc;
    assign if2.accmodule = acc;
    assign if3.accmodule = acc;

    logic o_req, o_done, o_beat, o_busy, o_ready;
    int   o_idx, o_nb;

    always_comb begin
        o_req = 1'b0; o_done = 1'b0; o_beat = 1'b0; o_busy = 1'b0; o_ready = 1'b0;
        o_idx = 0; o_nb = 0;
        case (sel)
            1: begin
                o_req = if1.req; o_done = if1.done; o_beat = if1.beat; o_busy = if1.busy;
                o_ready = if1.job_ready; o_idx = int'(if1.beat_idx); o_nb = int'(if1.nb_preempt);
            end
            2: begin
                o_req = if2.req; o_done = if2.done; o_beat = if2.beat; o_busy = if2.busy;
                o_ready = if2.job_ready; o_idx = int'(if2.beat_idx); o_nb = int'(if2.nb_preempt);
            end
            default: begin
                o_req = if3.req; o_done = if3.done; o_beat = if3.beat; o_busy = if3.busy;
                o_ready = if3.job_ready; o_idx = int'(if3.beat_idx); o_nb = int'(if3.nb_preempt);
            end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         sel;
        logic       jv;
        logic [7:0] len;
        logic [1:0] acc;
        logic       req, done, beat;
        int         idx;
        logic       busy, ready;
        int         nb;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int s, int v, int l, int a, int rq, int dn, int bt, int ix,
                                int bs, int rd, int nb);
        vec_t t;
        t.sel = s; t.jv = v[0]; t.len = l[7:0]; t.acc = a[1:0];
        t.req = rq[0]; t.done = dn[0]; t.beat = bt[0]; t.idx = ix;
        t.busy = bs[0]; t.ready = rd[0]; t.nb = nb;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int rq, input int dn, input int bs,
                           input int rd, input int nb);
        chk({tag, " req"},  int'(o_req),   rq);
        chk({tag, " done"}, int'(o_done),  dn);
        chk({tag, " busy"}, int'(o_busy),  bs);
        chk({tag, " ready"}, int'(o_ready), rd);
        chk({tag, " nb"},   o_nb,          nb);
    endtask

    initial begin
        int sat_acc[6];
        n_chk = 0; n_err = 0;
        sel = 1; jv = 1'b0; len = '0; acc = 2'd0;
        reset = 1'b1;

        // Reset values, checked while reset is still held
        #1;
        chk_all("reset m1", 0, 0, 0, 1, 0);
        chk("reset m1 idx", o_idx, 0);
        sel = 3; #1;
        chk_all("reset m3", 0, 0, 0, 1, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        //        sel jv len acc  req done beat idx busy ready nb
        // M1, 4 beats, grant from the second REQ cycle
        tbl.push_back(mk(1, 1, 3, 0,  0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1,  1, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1,  1, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1,  1, 0, 1, 2, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1,  1, 0, 1, 3, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1,  0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1,  0, 0, 0, 0, 0, 1, 0));
        // M2, 5 beats, preempted by M1 for 3 cycles; job_valid during XFER ignored
        tbl.push_back(mk(2, 1, 4, 0,  0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(2, 0, 0, 2,  1, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(2, 0, 0, 2,  1, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(2, 0, 0, 1,  1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(2, 0, 0, 1,  1, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(2, 0, 0, 1,  1, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(2, 0, 0, 2,  1, 0, 1, 2, 1, 0, 1));
        tbl.push_back(mk(2, 1, 0, 2,  1, 0, 1, 3, 1, 0, 1));
        tbl.push_back(mk(2, 0, 0, 2,  1, 0, 1, 4, 1, 0, 1));
        tbl.push_back(mk(2, 0, 0, 0,  0, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk(2, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1));
        // M3, 3 beats, grant toggling 3/1 every cycle
        tbl.push_back(mk(3, 1, 2, 0,  0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(3, 0, 0, 3,  1, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(3, 0, 0, 1,  1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(3, 0, 0, 3,  1, 0, 1, 1, 1, 0, 1));
        tbl.push_back(mk(3, 0, 0, 1,  1, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(3, 0, 0, 3,  1, 0, 1, 2, 1, 0, 2));
        tbl.push_back(mk(3, 0, 0, 1,  0, 1, 0, 0, 1, 0, 2));
        tbl.push_back(mk(3, 0, 0, 3,  0, 0, 0, 0, 0, 1, 2));
        // M1, single beat: job_ready low for 3 cycles
        tbl.push_back(mk(1, 1, 0, 0,  0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1,  1, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1,  0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0));

        foreach (tbl[i]) begin
            @(negedge clk);
            sel = tbl[i].sel; jv = tbl[i].jv; len = tbl[i].len; acc = tbl[i].acc;
            #1;
            chk_all($sformatf("v%0d", i), int'(tbl[i].req), int'(tbl[i].done),
                    int'(tbl[i].busy), int'(tbl[i].ready), tbl[i].nb);
            chk($sformatf("v%0d beat", i), int'(o_beat), int'(tbl[i].beat));
            if (tbl[i].beat) chk($sformatf("v%0d idx", i), o_idx, tbl[i].idx);
        end

        // M2, maximum job of 256 beats with a steady grant
        @(negedge clk);
        sel = 2; jv = 1'b1; len = 8'd255; acc = 2'd0;
        @(negedge clk);
        jv = 1'b0; acc = 2'd2;
        for (int k = 0; k < 256; k++) begin
            #1;
            chk($sformatf("long beat %0d", k), int'(o_beat), 1);
            chk($sformatf("long idx %0d", k), o_idx, k);
            @(negedge clk);
        end
        #1;
        chk_all("long end", 0, 1, 1, 0, 1);
        chk("long end beat", int'(o_beat), 0);
        @(negedge clk);
        acc = 2'd0;
        #1;
        chk_all("long idle", 0, 0, 0, 1, 1);

        // M3 with a 2-bit preemption counter: two more losses saturate it at 3
        sat_acc = '{3, 1, 3, 1, 3, 3};
        @(negedge clk);
        sel = 3; jv = 1'b1; len = 8'd3; acc = 2'd0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            jv = 1'b0; acc = 2'(sat_acc[k]);
        end
        @(negedge clk);
        acc = 2'd0;
        #1;
        chk("sat done", int'(o_done), 1);
        chk("sat nb", o_nb, 3);

        // M1, reset during beat 1: cleared at once, no done, next job restarts at 0
        @(negedge clk);
        sel = 1; jv = 1'b1; len = 8'd4; acc = 2'd0;
        @(negedge clk);
        jv = 1'b0; acc = 2'd1;
        @(negedge clk);
        #1;
        chk("pre-rst idx", o_idx, 1);
        reset = 1'b1;
        #1;
        chk_all("rst mid", 0, 0, 0, 1, 0);
        chk("rst mid idx", o_idx, 0);
        chk("rst mid beat", int'(o_beat), 0);
        chk("rst m3 nb", int'(if3.nb_preempt), 0);
        @(negedge clk);
        reset = 1'b0; acc = 2'd0;
        #1;
        chk_all("post-rst", 0, 0, 0, 1, 0);
        @(negedge clk);
        jv = 1'b1; len = 8'd1;
        @(negedge clk);
        jv = 1'b0; acc = 2'd1;
        #1;
        chk("new job idx0", o_idx, 0);
        chk("new job beat0", int'(o_beat), 1);
        @(negedge clk);
        #1;
        chk("new job idx1", o_idx, 1);
        @(negedge clk);
        acc = 2'd0;
        #1;
        chk("new job done", int'(o_done), 1);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/module_requester.md
# module_requester

Module-side agent for the three-way access controller: converts a locally issued transfer job into the controller's `req`/`done` handshake, tracks the grant on `accmodule`, and counts granted beats. One instance per module (M1, M2, M3) sits between the module's datapath and the controller. It survives M1 preemption of M2/M3 by pausing and resuming without losing beats.

## Interface

Parameters:
- `MODULE_ID`, default 1: this instance's grant code on `accmodule`; legal values 1 (M1), 2 (M2), 3 (M3).
- `LEN_W`, default 8: width of the job length and the beat index.
- `CNT_W`, default 8: width of the preemption counter.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `job_valid`  in  1: job offered.
- `job_len`  in  LEN_W: job length; beats = `job_len` + 1, so the range is 1..2^LEN_W.
- `job_ready`  out  1: asserted while the block can accept a job.
- `accmodule`  in  2: controller grant code; 0 = none, 1/2/3 = M1/M2/M3.
- `req`  out  1: request to the controller; this instance's bit of `req[2:0]`.
- `done`  out  1: one-cycle completion pulse; this instance's bit of `done[2:0]`.
- `beat`  out  1: high in each cycle this module owns the controller while a job is active.
- `beat_idx`  out  LEN_W: index of the current beat, starting at 0.
- `busy`  out  1: a job is in progress.
- `nb_preempt`  out  CNT_W: count of grant losses during an active job; saturates at all-ones.

## Operation

- States are IDLE, REQ, XFER, PAUSED and DONE. `granted` = (`accmodule` == MODULE_ID).
- IDLE:
  - `job_ready`=1.
  - When `job_valid` is high, latch `last` = `job_len`, clear the beat counter, and go to REQ.
- REQ: `req`=1. If `granted`, assert `beat` and go to XFER.
- XFER:
  - `req`=1.
  - If `granted`: `beat`=1 and the counter increments.
  - If not `granted`: this is a preemption. Go to PAUSED and increment `nb_preempt`, saturating.
- PAUSED: `req` stays 1 and no beat is issued. If `granted`, assert `beat` and go back to XFER.
- Last beat: a `beat` with counter == `last` moves the block to DONE, from any of REQ, XFER or PAUSED.
- DONE:
  - `done`=1 and `req`=0 for exactly one cycle, then IDLE.
  - The beat counter is not wrapped past `last`.
- Grants outside REQ, XFER and PAUSED are ignored: no beat, no count.
- `beat` is combinational from state and `accmodule`. All other outputs are registered.
- `beat_idx` = counter value. It is valid only while `beat`=1.
- `busy` = state is not IDLE.
- `nb_preempt` accumulates across jobs and is cleared only by `reset`.

## Timing

- Reset values: state IDLE, `req`=0, `done`=0, `job_ready`=1, `busy`=0, `beat_idx`=0, `nb_preempt`=0.
- Job accepted at edge t: `req`=1 from t+1.
- The first `beat` occurs in the first cycle after t with `granted`.
- Last beat at edge u: `done`=1 and `req`=0 during cycle u+1. `job_ready`=1 from u+2.
- Minimum turnaround: a 1-beat job with the grant in the cycle after `req` rises gives `done` 2 cycles after acceptance.
- `job_valid` while not IDLE is ignored; there is no queueing.
- Grant loss and the last beat in the same cycle cannot occur: the last beat needs `granted`.
- Reset asserted mid-job returns the block to reset values immediately and drops the job, with no `done`.
- A beat count of 2^LEN_W is legal; the counter never overflows because the compare against `last` stops it.

## Structure

- The shared package `ctrl_pkg` holds:
  - the `accmodule` codes ACC_NONE/ACC_M1/ACC_M2/ACC_M3;
  - the M1/M2/M3 bit positions 0/1/2;
  - the requester state enum.
- No sub-module is needed. The saturating counter is small enough to stay inline.

## Test plan

- Reset, then a job with `job_len`=3 and `accmodule` tied to ID starting the cycle after `req` rises -> `beat_idx` 0,1,2,3 on consecutive cycles, `done` one cycle later, `nb_preempt`=0.
- MODULE_ID=2, `job_len`=4, grant held 2 cycles, then `accmodule`=1 for 3 cycles, then 2 again -> `req` held high throughout, beats 0,1 then 2,3,4, `done` after beat 4, `nb_preempt`=1.
- MODULE_ID=3, `accmodule` toggling 3/1 every cycle for `job_len`=2 -> 3 beats total, `nb_preempt`=2, no duplicate index.
- `job_len`=0 with immediate grant -> single beat at index 0, `done` 2 cycles after acceptance, `job_ready` low for 3 cycles.
- `reset` pulsed during beat 1 of a 5-beat job -> `req`, `busy` and `beat_idx` cleared immediately, no `done`; a new job afterwards starts at index 0.
- `accmodule`=ID while IDLE, and `job_valid` asserted during XFER -> no beat, no counter change, second job not accepted.
